// File: rtl/audio_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_ram_pkg
//  Description : Shared types and constants for the audio RAM capture writer.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_ram_pkg;

    // Default word-address width of the on-chip RAM port (1024 words)
    localparam int ADDR_W_DEF = 10;

    // Every write covers the full 32-bit word
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

    // One stereo sample as stored in RAM: left in the upper half-word
    typedef struct packed {
        logic [15:0] left;
        logic [15:0] right;
    } sample_t;

    // Write-master states
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_fifo
//  Description : Synchronous FIFO with registered full/empty flags and
//                simultaneous push/pop. Also exposes the entry that becomes
//                the head after a pop, so the consumer can chain transfers
//                back to back without a bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] next_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             full_next_o,
    output logic             nonempty_next_o
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic             w_do_push, w_do_pop;

    assign w_do_push    = push_i && !full_q;
    assign w_do_pop     = pop_i && !empty_q;
    assign w_rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    // Pointer and occupancy next-state
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_do_pop) begin
            rd_ptr_d = w_rd_ptr_nxt;
        end
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_FULL);
            empty_q  <= (count_d == '0);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o          = mem_q[rd_ptr_q];
    // With a single entry, the follower can only be the word arriving now
    assign next_o          = (count_q >= CNT_TWO) ? mem_q[w_rd_ptr_nxt] : push_data_i;
    assign full_o          = full_q;
    assign empty_o         = empty_q;
    assign full_next_o     = (count_d == CNT_FULL);
    assign nonempty_next_o = (count_d != '0);

endmodule
`default_nettype wire

// File: rtl/audio_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_ram_writer
//  Description : Avalon-MM write master that drains a stereo sample stream
//                into on-chip RAM as a circular capture buffer, raising a
//                sticky interrupt whenever a half-buffer fills.
//  Options     : AUDIO_RAM_WRITER_OVF_CNT_EN - implements the saturating
//                dropped-sample counter; otherwise overflow_cnt reads 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_ram_writer
    import audio_ram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 1024,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_left,
    input  logic [15:0]       in_right,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic              m_waitrequest,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              irq,
    input  logic              irq_ack,
    output logic              half_id,
    output logic [15:0]       overflow_cnt
);

    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_HALF = ADDR_W'(DEPTH / 2 - 1);

    wr_state_t         state_q, state_d;
    logic              m_write_q, m_write_d;
    sample_t           wdata_q, wdata_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              irq_q, irq_d;
    logic              half_q, half_d;
    logic              in_ready_q;
    logic              pop_d;

    sample_t w_sample;
    sample_t w_fifo_head, w_fifo_next;
    logic    w_push;
    logic    w_fifo_full, w_fifo_empty, w_fifo_full_next, w_fifo_nonempty_next;

    assign w_sample = '{left: in_left, right: in_right};
    // in_ready_q already implies a non-full FIFO; the extra term keeps the
    // push strictly tied to the registered flag
    assign w_push   = in_valid && in_ready_q && !w_fifo_full;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(sample_t))
    ) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push_i          (w_push),
        .push_data_i     (w_sample),
        .pop_i           (pop_d),
        .head_o          (w_fifo_head),
        .next_o          (w_fifo_next),
        .full_o          (w_fifo_full),
        .empty_o         (w_fifo_empty),
        .full_next_o     (w_fifo_full_next),
        .nonempty_next_o (w_fifo_nonempty_next)
    );

    // Master FSM: load head, hold under waitrequest, pop and chain on completion
    always_comb begin
        state_d   = state_q;
        m_write_d = m_write_q;
        wdata_d   = wdata_q;
        wr_ptr_d  = wr_ptr_q;
        half_d    = half_q;
        irq_d     = irq_q && !irq_ack;
        pop_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    wdata_d   = w_fifo_head;
                    m_write_d = 1'b1;
                    state_d   = S_WRITE;
                end else if (restart) begin
                    wr_ptr_d = '0;
                end
            end
            S_WRITE: begin
                if (!m_waitrequest) begin
                    pop_d    = 1'b1;
                    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ADDR_W'(1);
                    // A set overrides an acknowledge in the same cycle
                    if (wr_ptr_q == PTR_HALF) begin
                        irq_d  = 1'b1;
                        half_d = 1'b0;
                    end else if (wr_ptr_q == PTR_LAST) begin
                        irq_d  = 1'b1;
                        half_d = 1'b1;
                    end
                    if (w_fifo_nonempty_next) begin
                        wdata_d = w_fifo_next;
                    end else begin
                        m_write_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                m_write_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            m_write_q  <= 1'b0;
            wdata_q    <= '0;
            wr_ptr_q   <= '0;
            irq_q      <= 1'b0;
            half_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_write_q  <= m_write_d;
            wdata_q    <= wdata_d;
            wr_ptr_q   <= wr_ptr_d;
            irq_q      <= irq_d;
            half_q     <= half_d;
            in_ready_q <= enable && !w_fifo_full_next;
        end
    end

`ifdef AUDIO_RAM_WRITER_OVF_CNT_EN
    logic [15:0] ovf_q;
    logic        w_drop;

    // The codec cannot stall, so a sample offered into a full FIFO is lost
    assign w_drop = in_valid && enable && w_fifo_full;

    // Saturating count of lost samples
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else if (w_drop && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign overflow_cnt = ovf_q;
`else
    assign overflow_cnt = 16'h0000;
`endif

    assign in_ready     = in_ready_q;
    assign m_address    = ADDR_W'(BASE_ADDR) + wr_ptr_q;
    assign m_write      = m_write_q;
    assign m_chipselect = m_write_q;
    assign m_byteenable = BYTEEN_ALL;
    assign m_writedata  = wdata_q;
    assign m_clken      = 1'b1;
    assign wr_ptr       = wr_ptr_q;
    assign irq          = irq_q;
    assign half_id      = half_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_ram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_ram_writer
//  Description : Directed self-checking bench for audio_ram_writer.
//                Honours AUDIO_RAM_WRITER_OVF_CNT_EN for the drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_ram_writer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

`ifdef AUDIO_RAM_WRITER_OVF_CNT_EN
    localparam logic [15:0] OVF_ONE = 16'd1;
`else
    localparam logic [15:0] OVF_ONE = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              restart = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_left = '0;
    logic [15:0]       in_right = '0;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic              m_clken;
    logic              m_waitrequest = 1'b0;
    logic [ADDR_W-1:0] wr_ptr;
    logic              irq;
    logic              irq_ack = 1'b0;
    logic              half_id;
    logic [15:0]       overflow_cnt;

    audio_ram_writer #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .restart       (restart),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .m_address     (m_address),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_byteenable  (m_byteenable),
        .m_writedata   (m_writedata),
        .m_clken       (m_clken),
        .m_waitrequest (m_waitrequest),
        .wr_ptr        (wr_ptr),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .half_id       (half_id),
        .overflow_cnt  (overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   nxt_ptr = 0;
    int   wr_count = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one sample; a handshake-accepted sample is expected at the next slot
    task automatic push_sample(input logic [31:0] s, output logic rdy);
        @(negedge clk);
        in_valid = 1'b1;
        {in_left, in_right} = s;
        rdy = in_ready;
        if (in_ready) begin
            exp_q.push_back('{addr: nxt_ptr, data: s});
            nxt_ptr = (nxt_ptr + 1) % DEPTH;
        end
    endtask

    task automatic stop_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_write) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_mwrite", 32'(m_write), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_m_write"}, 32'(m_write), 32'd0);
        check({tag, "_m_cs"}, 32'(m_chipselect), 32'd0);
        check({tag, "_m_addr"}, 32'(m_address), 32'd0);
        check({tag, "_m_wdata"}, m_writedata, 32'd0);
        check({tag, "_wr_ptr"}, 32'(wr_ptr), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
        check({tag, "_half_id"}, 32'(half_id), 32'd0);
        check({tag, "_ovf"}, 32'(overflow_cnt), 32'd0);
        check({tag, "_byteen"}, 32'(m_byteenable), 32'hF);
        check({tag, "_clken"}, 32'(m_clken), 32'd1);
    endtask

    // Write monitor: every completed write must match the next expected
    // sample, and irq must follow a half-boundary completion by one cycle
    initial begin
        logic pend_irq;
        logic pend_half;
        int   off;
        exp_t e;
        pend_irq  = 1'b0;
        pend_half = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (pend_irq) begin
                check("irq_after_half", 32'(irq), 32'd1);
                check("half_id_after_half", 32'(half_id), 32'(pend_half));
                pend_irq = 1'b0;
            end
            if (!reset && m_write && !m_waitrequest) begin
                check("m_cs_eq_write", 32'(m_chipselect), 32'd1);
                if (exp_q.size() == 0) begin
                    check("spurious_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(m_address), 32'(e.addr));
                    check("wr_data", m_writedata, e.data);
                    if (wr_count == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    wr_count++;
                    off = int'(m_address);
                    if (off == DEPTH / 2 - 1) begin
                        pend_irq  = 1'b1;
                        pend_half = 1'b0;
                    end else if (off == DEPTH - 1) begin
                        pend_irq  = 1'b1;
                        pend_half = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rdy;
        logic [31:0] s0;
        int          n;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // ---- 8 samples, no waitrequest: addresses 0..7, one per clock ----
        for (int i = 0; i < 8; i++) begin
            push_sample({16'(16'h0001 + i), 16'(16'h8000 + i)}, rdy);
            check("t1_ready", 32'(rdy), 32'd1);
        end
        stop_input();
        wait_drain();
        check("t1_wr_count", 32'(wr_count), 32'd8);
        check("t1_one_per_clk", 32'(last_cyc - first_cyc), 32'd7);
        check("t1_wr_ptr", 32'(wr_ptr), 32'd8);

        // ---- stall: FIFO absorbs 4, the 5th is dropped ----
        m_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_sample({16'(16'h1000 + i), 16'(16'h2000 + i)}, rdy);
            check("t2_ready", 32'(rdy), (i < 4) ? 32'd1 : 32'd0);
        end
        stop_input();
        check("t2_ovf", 32'(overflow_cnt), 32'(OVF_ONE));
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_write", 32'(m_write), 32'd1);
            check("t2_hold_addr", 32'(m_address), 32'd8);
            check("t2_hold_data", m_writedata, 32'h1000_2000);
            @(negedge clk);
        end
        m_waitrequest = 1'b0;
        wait_drain();
        check("t2_wr_ptr", 32'(wr_ptr), 32'd12);

        // ---- enable drop with 3 queued; restart ignored during drain ----
        m_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_sample({16'(16'h3000 + i), 16'(16'h4000 + i)}, rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b0;
        @(negedge clk);
        check("t5_ready_low", 32'(in_ready), 32'd0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5_restart_ignored", 32'(wr_ptr), 32'd12);
        m_waitrequest = 1'b0;
        wait_drain();
        check("t5_wr_ptr", 32'(wr_ptr), 32'd15);
        check("t5_ready_still_low", 32'(in_ready), 32'd0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        nxt_ptr = 0;
        check("t5_restart_idle", 32'(wr_ptr), 32'd0);
        check("t5_ovf_kept", 32'(overflow_cnt), 32'(OVF_ONE));
        enable = 1'b1;
        @(negedge clk);
        check("t5_ready_back", 32'(in_ready), 32'd1);

        // ---- full buffer stream: irq at each half, wrap ----
        check("t3_irq_idle", 32'(irq), 32'd0);
        for (int i = 0; i < DEPTH / 2; i++) begin
            push_sample({16'(i), 16'(i) ^ 16'hA5A5}, rdy);
        end
        stop_input();
        wait_drain();
        check("t3_irq_low_half", 32'(irq), 32'd1);
        check("t3_half_id_0", 32'(half_id), 32'd0);
        check("t3_wr_ptr_512", 32'(wr_ptr), 32'd512);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t3_irq_acked", 32'(irq), 32'd0);
        for (int i = DEPTH / 2; i < DEPTH; i++) begin
            push_sample({16'(i), 16'(i) ^ 16'hA5A5}, rdy);
        end
        stop_input();
        n = 0;
        while (!(m_write && m_address == ADDR_W'(DEPTH - 1)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_last_write_seen", 32'(m_address), 32'(DEPTH - 1));
        // Acknowledge in the very cycle the upper-half set happens
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t4_set_wins", 32'(irq), 32'd1);
        check("t4_half_id_1", 32'(half_id), 32'd1);
        check("t3_wrap", 32'(wr_ptr), 32'd0);
        wait_drain();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t4_irq_acked", 32'(irq), 32'd0);

        // ---- reset during a stalled write ----
        m_waitrequest = 1'b1;
        s0 = 32'hDEAD_BEEF;
        push_sample(s0, rdy);
        stop_input();
        @(negedge clk);
        check("t6_write_pending", 32'(m_write), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        nxt_ptr = 0;
        @(negedge clk);
        check_reset_outputs("t6");
        reset = 1'b0;
        m_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_fifo_empty", 32'(m_write), 32'd0);
        end
        check("t6_ready", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_ram_writer.md
# audio_ram_writer

Avalon-MM write master that drains a stereo audio sample stream into the Nios II on-chip RAM as a circular capture buffer. It sits directly upstream of the 1024 x 32 on-chip RAM slave. The interconnect arbitrates it against the CPU data master. It raises a sticky interrupt each time a half-buffer fills, so software can process one half while the other is written.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the RAM port
- DEPTH, 1024, buffer length in 32-bit words; power of two, at most 2^ADDR_W
- BASE_ADDR, 0, first word address of the buffer
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable (level)
- restart  in  1  one-cycle pulse that returns wr_ptr to 0; honoured only while idle
- in_valid  in  1  sample present
- in_ready  out  1  FIFO not full and enable high
- in_left  in  16  left sample, two's complement
- in_right  in  16  right sample, two's complement
- m_address  out  ADDR_W  word address, BASE_ADDR + wr_ptr
- m_chipselect  out  1  equals m_write
- m_write  out  1  write request
- m_byteenable  out  4  constant 4'hF
- m_writedata  out  32  {in_left, in_right}
- m_clken  out  1  constant 1
- m_waitrequest  in  1  interconnect stall
- wr_ptr  out  ADDR_W  next word offset to be written
- irq  out  1  sticky half-buffer interrupt
- irq_ack  in  1  clears irq
- half_id  out  1  half last completed: 0 = lower, 1 = upper
- overflow_cnt  out  16  dropped-sample count

## Operation
- Input side: a sample is accepted when in_valid && in_ready and pushed into the FIFO as {left, right}.
- Drop rule: the codec cannot stall. If in_valid is high while enable is high and the FIFO is full, the sample is dropped and overflow_cnt increments. The counter saturates at 16'hFFFF.
- Master FSM:
  - IDLE: when the FIFO is not empty, load the head entry into the output registers and go to WRITE.
  - WRITE: hold m_write, m_address and m_writedata stable while m_waitrequest is high.
  - On a cycle with m_write && !m_waitrequest: pop the FIFO and advance wr_ptr. If the FIFO is still non-empty, load the next entry and stay in WRITE (back-to-back). Otherwise go to IDLE.
- Wrap: wr_ptr advances DEPTH-1 -> 0, modulo DEPTH.
- Interrupt:
  - Completing the write at offset DEPTH/2-1 sets irq and sets half_id to 0.
  - Completing the write at offset DEPTH-1 sets irq and sets half_id to 1.
  - irq_ack clears irq. If a set and irq_ack occur in the same cycle, set wins.
- enable low: in_ready drops and no new samples are accepted. The FIFO drains completely, then the FSM rests in IDLE. An in-flight write always completes.
- restart: clears wr_ptr to 0 only when the FSM is in IDLE and the FIFO is empty; otherwise it is ignored. It does not clear overflow_cnt.
- Reset mid-transfer: everything returns to reset values at once and any pending write is abandoned. The interconnect tolerates m_write dropping, because the on-chip RAM slave never asserts waitrequest on its own.

## Timing
- Reset values: in_ready 0, m_write 0, m_chipselect 0, m_address BASE_ADDR, m_writedata 0, wr_ptr 0, irq 0, half_id 0, overflow_cnt 0, FIFO empty, FSM IDLE.
- in_ready is registered. It first rises the cycle after reset deasserts, provided enable is high.
- Latency: a sample accepted in cycle N is presented with m_write high in cycle N+1 at the earliest.
- wr_ptr updates in the cycle after write completion.
- irq rises in the cycle after completion of write DEPTH/2-1 or DEPTH-1.
- Throughput: 1 word per clock with no waitrequest.
- Simultaneous push and pop on a full FIFO:
  - in_ready is computed from the registered full flag, so no sample is accepted that cycle.
  - Drop counting uses the same registered flag, so a sample presented in that cycle counts as a drop.

## Configuration
- AUDIO_RAM_WRITER_OVF_CNT_EN defined: overflow_cnt is implemented as described.
- Undefined: overflow_cnt is tied to 16'h0000, the counter logic is absent, and drops still occur silently.

## Structure
- Package audio_ram_pkg holds:
  - ADDR_W_DEF
  - sample_t (struct with left and right, 16 bits each)
  - the FSM state enum {S_IDLE, S_WRITE}
  - constant BYTEEN_ALL = 4'hF
- One sub-module, audio_sample_fifo: synchronous FIFO of FIFO_DEPTH x 32 with registered full/empty flags, push/pop ports and simultaneous push/pop support.

## Test plan
- Reset, enable=1, 8 samples {16'h0001+i, 16'h8000+i} with no waitrequest -> 8 writes at addresses 0..7 with matching data, one per clock; wr_ptr = 8.
- m_waitrequest held high for 5 cycles on the 3rd write -> address and data held stable; the FIFO absorbs 4 samples and the 5th is dropped (overflow_cnt = 1).
- Stream 1024 samples with DEPTH=1024:
  - irq rises after write 511 with half_id=0.
  - irq_ack clears it.
  - irq rises again after write 1023 with half_id=1.
  - wr_ptr wraps to 0.
- irq_ack asserted in the same cycle irq would set -> irq stays 1.
- enable dropped with 3 entries queued -> all 3 written, in_ready=0, FSM reaches IDLE. A restart pulse then sets wr_ptr = 0, and a restart pulse issued during the drain is ignored.
- Reset asserted while m_write=1 and waitrequest=1 -> the next cycle shows all outputs at reset values and an empty FIFO.
